// File: rtl/program_loader_if.sv
// Host byte stream into the program loader: valid/ready handshake carrying
// length, code and checksum bytes.
interface program_loader_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_in,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_in,
    input  byte_valid,
    output byte_ready
  );
endinterface

// File: rtl/program_loader.sv
// Loads a length-prefixed, XOR-checksummed program into CPU instruction memory
// and releases the CPU from reset once the checksum matches.
module program_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  program_loader_if.slave   host,
  output logic [7:0]        instruction_write_data,
  output logic [ADDR_W-1:0] write_addr,
  output logic              ins_write,
  output logic              ins_read,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    LOAD,
    CHK,
    RELEASE,
    RUN,
    ERROR
  } state_t;

  state_t     state;
  logic [7:0] count;
  logic [7:0] idx;
  logic [7:0] acc;
  logic       ready;
  logic       accept;

  assign ready          = (state == LEN) || (state == LOAD) || (state == CHK);
  assign host.byte_ready = ready;
  assign accept         = host.byte_valid && ready;

  // Outputs are registered together with the state so each state's output
  // values appear in the same cycle the state becomes current.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                  <= IDLE;
      count                  <= 8'd0;
      idx                    <= 8'd0;
      acc                    <= 8'd0;
      instruction_write_data <= 8'd0;
      write_addr             <= '0;
      ins_write              <= 1'b0;
      ins_read               <= 1'b0;
      cpu_reset              <= 1'b1;
      done                   <= 1'b0;
      error                  <= 1'b0;
    end else begin
      ins_write <= 1'b0;
      case (state)
        IDLE: begin
          if (start) state <= LEN;
        end
        LEN: begin
          if (accept) begin
            count <= host.byte_in;
            if (host.byte_in == 8'd0) begin
              state <= ERROR;
              error <= 1'b1;
            end else begin
              idx   <= 8'd0;
              acc   <= 8'd0;
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            instruction_write_data <= host.byte_in;
            write_addr             <= ADDR_W'(idx);
            ins_write              <= 1'b1;
            acc                    <= acc ^ host.byte_in;
            idx                    <= idx + 8'd1;
            if (idx + 8'd1 == count) state <= CHK;
          end
        end
        CHK: begin
          if (accept) begin
            if (host.byte_in == acc) begin
              state    <= RELEASE;
              ins_read <= 1'b1;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
        end
        RELEASE: begin
          state     <= RUN;
          cpu_reset <= 1'b0;
          done      <= 1'b1;
        end
        RUN: begin
          // A new start aborts the running program and reloads.
          if (start) begin
            state     <= LEN;
            cpu_reset <= 1'b1;
            ins_read  <= 1'b0;
            done      <= 1'b0;
          end
        end
        ERROR: begin
          if (start) begin
            state <= LEN;
            error <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          cpu_reset <= 1'b1;
          ins_read  <= 1'b0;
          done      <= 1'b0;
          error     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed scenarios plus randomized loads, all
// checked every cycle against a transaction-level model of the loader.
module tb_program_loader;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        instruction_write_data;
  logic [ADDR_W-1:0] write_addr;
  logic              ins_write;
  logic              ins_read;
  logic              cpu_reset;
  logic              done;
  logic              error;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  program_loader_if bus ();

  program_loader #(.ADDR_W(ADDR_W)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .start                  (start),
    .host                   (bus),
    .instruction_write_data (instruction_write_data),
    .write_addr             (write_addr),
    .ins_write              (ins_write),
    .ins_read               (ins_read),
    .cpu_reset              (cpu_reset),
    .done                   (done),
    .error                  (error)
  );

  // Model: flags for "waiting for length / checksum", bytes still to load,
  // release/run/error flags, plus the last expected memory write.
  bit         m_len, m_chk, m_rel, m_run, m_err;
  int         m_left;
  int         m_idx;
  logic [7:0] m_acc;
  bit         e_wr;
  logic [7:0] e_data;
  logic [7:0] e_addr;
  bit         m_ready;
  bit         m_take;

  assign m_ready = m_len || (m_left > 0) || m_chk;
  assign m_take  = m_ready && bus.byte_valid;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_len  <= 1'b0;
      m_chk  <= 1'b0;
      m_rel  <= 1'b0;
      m_run  <= 1'b0;
      m_err  <= 1'b0;
      m_left <= 0;
      m_idx  <= 0;
      m_acc  <= 8'd0;
      e_wr   <= 1'b0;
      e_data <= 8'd0;
      e_addr <= 8'd0;
    end else begin
      e_wr <= 1'b0;
      if (m_len) begin
        if (m_take) begin
          m_len <= 1'b0;
          if (bus.byte_in == 8'd0) m_err <= 1'b1;
          else begin
            m_left <= int'(bus.byte_in);
            m_idx  <= 0;
            m_acc  <= 8'd0;
          end
        end
      end else if (m_left > 0) begin
        if (m_take) begin
          e_wr   <= 1'b1;
          e_data <= bus.byte_in;
          e_addr <= 8'(m_idx);
          m_idx  <= m_idx + 1;
          m_acc  <= m_acc ^ bus.byte_in;
          m_left <= m_left - 1;
          if (m_left == 1) m_chk <= 1'b1;
        end
      end else if (m_chk) begin
        if (m_take) begin
          m_chk <= 1'b0;
          if (bus.byte_in == m_acc) m_rel <= 1'b1;
          else m_err <= 1'b1;
        end
      end else if (m_rel) begin
        m_rel <= 1'b0;
        m_run <= 1'b1;
      end else if (m_run) begin
        if (start) begin
          m_run <= 1'b0;
          m_len <= 1'b1;
        end
      end else if (m_err) begin
        if (start) begin
          m_err <= 1'b0;
          m_len <= 1'b1;
        end
      end else begin
        if (start) m_len <= 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("byte_ready", 32'(bus.byte_ready), 32'(m_ready));
      checkOutput("ins_write", 32'(ins_write), 32'(e_wr));
      checkOutput("instruction_write_data", 32'(instruction_write_data), 32'(e_data));
      checkOutput("write_addr", 32'(write_addr), 32'(e_addr));
      checkOutput("cpu_reset", 32'(cpu_reset), 32'(!m_run));
      checkOutput("ins_read", 32'(ins_read), 32'(m_rel || m_run));
      checkOutput("done", 32'(done), 32'(m_run));
      checkOutput("error", 32'(error), 32'(m_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Present one byte after `stalls` idle cycles; noise toggles start in the gaps.
  task automatic applyStimulus(input logic [7:0] b, input int stalls, input bit noise);
    for (int i = 0; i < stalls; i++) begin
      bus.byte_valid = 1'b0;
      bus.byte_in    = 8'($urandom);
      start          = noise && ($urandom_range(0, 5) == 0);
      step();
    end
    start          = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_in    = b;
    step();
    bus.byte_valid = 1'b0;
  endtask

  int         n;
  logic [7:0] x;
  logic [7:0] b;

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'd0;
    #2 reset = 1'b0;
    #1;
    checkOutput("rst cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("rst byte_ready", 32'(bus.byte_ready), 32'd0);
    checkOutput("rst ins_write", 32'(ins_write), 32'd0);
    checkOutput("rst ins_read", 32'(ins_read), 32'd0);
    checkOutput("rst done", 32'(done), 32'd0);
    checkOutput("rst error", 32'(error), 32'd0);
    checkOutput("rst write_addr", 32'(write_addr), 32'd0);
    checkOutput("rst data", 32'(instruction_write_data), 32'd0);
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Nominal load
    pulse_start();
    checkOutput("nom len ready", 32'(bus.byte_ready), 32'd1);
    applyStimulus(8'h02, 0, 1'b0);
    applyStimulus(8'hC9, 0, 1'b0);
    checkOutput("nom wr0 strobe", 32'(ins_write), 32'd1);
    checkOutput("nom wr0 addr", 32'(write_addr), 32'd0);
    checkOutput("nom wr0 data", 32'(instruction_write_data), 32'hC9);
    applyStimulus(8'h0A, 0, 1'b0);
    checkOutput("nom wr1 addr", 32'(write_addr), 32'd1);
    checkOutput("nom wr1 data", 32'(instruction_write_data), 32'h0A);
    applyStimulus(8'hC3, 0, 1'b0);
    checkOutput("release cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("release ins_read", 32'(ins_read), 32'd1);
    checkOutput("release done", 32'(done), 32'd0);
    step();
    checkOutput("run cpu_reset", 32'(cpu_reset), 32'd0);
    checkOutput("run done", 32'(done), 32'd1);
    checkOutput("run ins_read", 32'(ins_read), 32'd1);
    step();

    // Restart from RUN
    pulse_start();
    checkOutput("restart done", 32'(done), 32'd0);
    checkOutput("restart ins_read", 32'(ins_read), 32'd0);
    checkOutput("restart cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("restart byte_ready", 32'(bus.byte_ready), 32'd1);

    // Bad checksum
    applyStimulus(8'h01, 0, 1'b0);
    applyStimulus(8'h55, 0, 1'b0);
    checkOutput("bad wr addr", 32'(write_addr), 32'd0);
    checkOutput("bad wr data", 32'(instruction_write_data), 32'h55);
    applyStimulus(8'h00, 0, 1'b0);
    checkOutput("bad error", 32'(error), 32'd1);
    checkOutput("bad cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("bad ins_read", 32'(ins_read), 32'd0);
    pulse_start();
    checkOutput("bad restart error", 32'(error), 32'd0);
    checkOutput("bad restart ready", 32'(bus.byte_ready), 32'd1);

    // Zero length
    applyStimulus(8'h00, 0, 1'b0);
    checkOutput("zero error", 32'(error), 32'd1);
    checkOutput("zero ins_write", 32'(ins_write), 32'd0);
    pulse_start();

    // Stalls between code bytes
    applyStimulus(8'h02, 0, 1'b0);
    applyStimulus(8'hC9, 0, 1'b0);
    applyStimulus(8'h0A, 3, 1'b0);
    checkOutput("stall wr1 addr", 32'(write_addr), 32'd1);
    checkOutput("stall wr1 data", 32'(instruction_write_data), 32'h0A);
    applyStimulus(8'hC3, 1, 1'b0);
    step();
    checkOutput("stall done", 32'(done), 32'd1);

    // Longest program
    pulse_start();
    applyStimulus(8'hFF, 0, 1'b0);
    x = 8'd0;
    for (int k = 0; k < 255; k++) begin
      b = 8'($urandom);
      x = x ^ b;
      applyStimulus(b, 0, 1'b0);
    end
    checkOutput("long last addr", 32'(write_addr), 32'd254);
    applyStimulus(x, 0, 1'b0);
    step();
    checkOutput("long done", 32'(done), 32'd1);

    // Async reset in the middle of a load
    pulse_start();
    applyStimulus(8'h03, 0, 1'b0);
    applyStimulus(8'h11, 0, 1'b0);
    applyStimulus(8'h22, 0, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("midrst ins_write", 32'(ins_write), 32'd0);
    checkOutput("midrst ready", 32'(bus.byte_ready), 32'd0);
    checkOutput("midrst cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("midrst addr", 32'(write_addr), 32'd0);
    checkOutput("midrst done", 32'(done), 32'd0);
    #4 reset = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(8'h33, 0, 1'b0);
    checkOutput("post rst ins_write", 32'(ins_write), 32'd0);
    checkOutput("post rst ready", 32'(bus.byte_ready), 32'd0);

    // Randomized loads with stalls, stray start pulses and corrupt checksums
    for (int t = 0; t < 40; t++) begin
      pulse_start();
      n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
      applyStimulus(8'(n), int'($urandom_range(0, 2)), 1'b1);
      if (n > 0) begin
        x = 8'd0;
        for (int k = 0; k < n; k++) begin
          b = 8'($urandom);
          x = x ^ b;
          applyStimulus(b, int'($urandom_range(0, 3)), 1'b1);
        end
        if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
        applyStimulus(x, int'($urandom_range(0, 2)), 1'b1);
      end
      repeat ($urandom_range(1, 4)) step();
    end

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
